adv_timer_b_ctrl: RTL and testbench
===================================

# adv_timer_b_ctrl

Command controller for one advanced-timer counter. It arbitrates START/STOP/UPDATE/RESET/ARM commands from several requesters, such as the register-file path and event-linking logic, and runs a run-state machine. It drives the counter's enable, clear and threshold-load controls. UPDATE commands issued while the counter runs are held in shadow registers and applied at the counter's end-of-period.

## Interface
- N_REQ, 2, number of command requesters (2..8)
- CNT_W, 16, counter/threshold width
- clk_i  in  1  clock; all logic on rising edge
- rstn_i  in  1  reset, synchronous, active-low
- req_valid_i  in  N_REQ  per-requester command valid
- req_cmd_i  in  3*N_REQ  per-requester command; slice i = [3*i+2:3*i]
- req_lo_i  in  CNT_W*N_REQ  per-requester low threshold (UPDATE only)
- req_hi_i  in  CNT_W*N_REQ  per-requester high threshold (UPDATE only)
- req_ready_o  out  N_REQ  grant, combinational, one-hot or zero
- trig_i  in  1  external start trigger, level-sampled in ARMED
- cntr_eop_i  in  1  end-of-period pulse from counter
- cntr_en_o  out  1  counter enable
- cntr_clr_o  out  1  counter clear, 1-cycle pulse
- cntr_load_o  out  1  threshold load strobe, 1-cycle pulse
- th_lo_o  out  CNT_W  low threshold presented with cntr_load_o
- th_hi_o  out  CNT_W  high threshold presented with cntr_load_o
- state_o  out  2  0 IDLE, 1 ARMED, 2 RUN
- pend_o  out  1  UPDATE pending in shadow
- err_o  out  1  illegal-command pulse

## Operation
- Command encoding: 0 NOP, 1 START, 2 STOP, 3 UPDATE, 4 RESET, 5 ARM, 6–7 illegal.
- Arbitration is round-robin, with at most one command accepted per cycle.
  - The search starts at pointer `ptr`. The first index with valid set gets req_ready_o.
  - A transfer occurs when valid and ready are both high. `ptr` then becomes the granted index + 1, modulo N_REQ.
  - `ptr` is unchanged when nothing is granted.
  - Requesters hold valid and payload until ready.
- NOP is accepted with no effect. Illegal codes are accepted with no state effect and raise err_o.
- FSM states IDLE, ARMED, RUN; outputs registered.
  - START: IDLE/ARMED → RUN. In RUN, no effect.
  - STOP: any → IDLE. A pending shadow is applied (load pulse) and pend cleared.
  - ARM: IDLE → ARMED. In ARMED or RUN, no effect.
  - ARMED and trig_i=1 with no command accepted → RUN.
  - RESET: cntr_clr_o pulse, state → IDLE, pending shadow discarded (pend cleared, no load).
  - UPDATE in IDLE/ARMED: th_lo_o/th_hi_o take the payload and cntr_load_o pulses.
  - UPDATE in RUN: payload written to the shadow and pend_o set. A later UPDATE before eop overwrites the shadow.
  - RUN and cntr_eop_i with pend=1: the shadow goes to th_*_o, cntr_load_o pulses, pend cleared.
- cntr_en_o = (state == RUN), registered.
- th_lo_o/th_hi_o hold their value between loads.

## Timing
- Reset: while rstn_i=0 at an edge, all outputs are 0 at the next cycle. This covers state IDLE, ptr 0, shadow 0, th_lo_o/th_hi_o 0, and pend, clr, load, err and en all 0. req_ready_o is 0 while in reset.
- Reset mid-operation aborts any pending update; no load pulse is emitted.
- Command accepted in cycle T: state_o, cntr_en_o, cntr_clr_o, cntr_load_o, th_*_o, pend_o and err_o change at T+1.
- Trigger sampled in ARMED at T: RUN and cntr_en_o=1 at T+1.
- eop at T with pend: cntr_load_o=1 and new thresholds at T+1.
- Pulses last exactly one cycle, with no back-to-back merging. Consecutive commands can produce pulses in consecutive cycles.
- Simultaneous events:
  - Accepted command and trig_i in ARMED: the command wins and the trigger is ignored that cycle.
    - Exception: ARM or NOP with trig_i still enters RUN.
  - UPDATE accepted in RUN in the same cycle as eop: the new payload loads at T+1 (new data wins) and pend clears.
  - STOP in the same cycle as eop with pend: a single load pulse of the shadow at T+1.
  - RESET in the same cycle as eop with pend: clear only, no load.
- cntr_eop_i is ignored outside RUN.

## Test plan
- Reset: drive rstn_i=0 for 3 cycles with all valids high → req_ready_o=0. After release, all outputs are 0 and state_o=0.
- Round-robin: N_REQ=2, both valid continuously with START/NOP → grants alternate 0,1,0,1. With only requester 1 valid, it is granted every cycle.
- Arm/trigger: ARM at T → state_o=1 at T+1. trig_i at T+3 → state_o=2 and cntr_en_o=1 at T+4. STOP and trig_i in the same cycle while ARMED → IDLE.
- Shadowed update: in RUN, UPDATE lo=0x0010 hi=0x0100, then UPDATE lo=0x0020 hi=0x0200 → pend_o=1, no load. eop at T → cntr_load_o=1 with th_lo_o=0x0020, th_hi_o=0x0200 at T+1, and pend_o=0.
- Immediate update and reset: UPDATE lo=0x0005 hi=0x000A in IDLE → load pulse at T+1. RESET in RUN with pend=1 and eop in the same cycle → cntr_clr_o=1, no cntr_load_o, state_o=0, pend_o=0.
- Illegal command: cmd=7 accepted → err_o pulse at T+1, state and thresholds unchanged, ptr advances.

Source files
------------

// File: rtl/adv_timer_b_ctrl.sv
// adv_timer_b_ctrl
// Command controller for one advanced-timer counter. Requesters are served
// round-robin, one command per cycle, and the accepted command drives a
// small IDLE/ARMED/RUN machine. Threshold updates received while running are
// parked in a shadow and applied at the counter's end-of-period.
//
// Ports
//   clk_i, rstn_i        clock, synchronous active-low reset
//   req_valid_i          per-requester command valid
//   req_cmd_i            per-requester 3-bit command, slice i = [3i+2:3i]
//   req_lo_i, req_hi_i   per-requester threshold payload (UPDATE)
//   req_ready_o          one-hot grant (combinational), zero in reset
//   trig_i               start trigger, level-sampled while ARMED
//   cntr_eop_i           end-of-period pulse from the counter
//   cntr_en_o            counter enable (state == RUN)
//   cntr_clr_o           counter clear pulse
//   cntr_load_o          threshold load strobe
//   th_lo_o, th_hi_o     thresholds presented with cntr_load_o
//   state_o              0 IDLE, 1 ARMED, 2 RUN
//   pend_o               shadow update pending
//   err_o                illegal-command pulse
//
// state  | meaning
// IDLE   | counter stopped, thresholds load immediately
// ARMED  | waiting for trig_i (or START) to begin counting
// RUN    | counter enabled, updates go through the shadow
module adv_timer_b_ctrl #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [3*N_REQ-1:0]     req_cmd_i,
  input  logic [CNT_W*N_REQ-1:0] req_lo_i,
  input  logic [CNT_W*N_REQ-1:0] req_hi_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic                   trig_i,
  input  logic                   cntr_eop_i,
  output logic                   cntr_en_o,
  output logic                   cntr_clr_o,
  output logic                   cntr_load_o,
  output logic [CNT_W-1:0]       th_lo_o,
  output logic [CNT_W-1:0]       th_hi_o,
  output logic [1:0]             state_o,
  output logic                   pend_o,
  output logic                   err_o
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [2:0] CMD_START  = 3'd1;
  localparam logic [2:0] CMD_STOP   = 3'd2;
  localparam logic [2:0] CMD_UPDATE = 3'd3;
  localparam logic [2:0] CMD_RESET  = 3'd4;
  localparam logic [2:0] CMD_ARM    = 3'd5;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   sh_lo_q, sh_lo_d, sh_hi_q, sh_hi_d;
  logic [CNT_W-1:0]   th_lo_q, th_lo_d, th_hi_q, th_hi_d;
  logic               pend_q, pend_d;
  logic               en_q, en_d;
  logic               clr_q, clr_d;
  logic               load_q, load_d;
  logic               err_q, err_d;

  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W:0]     idx_w;
  logic [2:0]         cmd_sel;
  logic [CNT_W-1:0]   lo_sel, hi_sel;
  logic               eop_apply;

  // Round-robin search starting at ptr_q; the wrap uses one extra bit so
  // non-power-of-two N_REQ works.
  always_comb begin
    req_ready_o = '0;
    grant_vld   = 1'b0;
    grant_idx   = '0;
    idx_w       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (idx_w >= (PTR_W+1)'(N_REQ)) idx_w = idx_w - (PTR_W+1)'(N_REQ);
      if (rstn_i && !grant_vld && req_valid_i[idx_w[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx_w[PTR_W-1:0];
      end
    end
    if (grant_vld) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    cmd_sel = req_cmd_i[3*grant_idx +: 3];
    lo_sel  = req_lo_i[CNT_W*grant_idx +: CNT_W];
    hi_sel  = req_hi_i[CNT_W*grant_idx +: CNT_W];
    ptr_d   = ptr_q;
    if (grant_vld) begin
      if (grant_idx == PTR_W'(N_REQ-1)) ptr_d = '0;
      else                              ptr_d = grant_idx + 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sh_lo_q <= '0;
      sh_hi_q <= '0;
      th_lo_q <= '0;
      th_hi_q <= '0;
      pend_q  <= 1'b0;
      en_q    <= 1'b0;
      clr_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sh_lo_q <= sh_lo_d;
      sh_hi_q <= sh_hi_d;
      th_lo_q <= th_lo_d;
      th_hi_q <= th_hi_d;
      pend_q  <= pend_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  // Next state. In ARMED an accepted command beats the trigger, except that
  // NOP/ARM leave the trigger free to start the counter.
  always_comb begin
    state_d = state_q;
    if (grant_vld) begin
      unique case (cmd_sel)
        CMD_START: state_d = ST_RUN;
        CMD_STOP,
        CMD_RESET: state_d = ST_IDLE;
        CMD_ARM: begin
          if (state_q == ST_IDLE)                  state_d = ST_ARMED;
          else if (state_q == ST_ARMED && trig_i) state_d = ST_RUN;
        end
        3'd0: if (state_q == ST_ARMED && trig_i) state_d = ST_RUN;
        default: ;
      endcase
    end else if (state_q == ST_ARMED && trig_i) begin
      state_d = ST_RUN;
    end
  end

  // Registered outputs and shadow handling.
  always_comb begin
    eop_apply = (state_q == ST_RUN) && cntr_eop_i && pend_q;
    en_d      = (state_d == ST_RUN);
    clr_d     = grant_vld && (cmd_sel == CMD_RESET);
    err_d     = grant_vld && (cmd_sel[2:1] == 2'b11);
    load_d    = 1'b0;
    th_lo_d   = th_lo_q;
    th_hi_d   = th_hi_q;
    sh_lo_d   = sh_lo_q;
    sh_hi_d   = sh_hi_q;
    pend_d    = pend_q;
    if (grant_vld && cmd_sel == CMD_UPDATE) begin
      // New data at end-of-period wins over the stale shadow.
      if (state_q != ST_RUN || cntr_eop_i) begin
        load_d  = 1'b1;
        th_lo_d = lo_sel;
        th_hi_d = hi_sel;
        pend_d  = 1'b0;
      end else begin
        sh_lo_d = lo_sel;
        sh_hi_d = hi_sel;
        pend_d  = 1'b1;
      end
    end else if (grant_vld && cmd_sel == CMD_RESET) begin
      sh_lo_d = '0;
      sh_hi_d = '0;
      pend_d  = 1'b0;
    end else if (eop_apply || (grant_vld && cmd_sel == CMD_STOP && pend_q)) begin
      load_d  = 1'b1;
      th_lo_d = sh_lo_q;
      th_hi_d = sh_hi_q;
      pend_d  = 1'b0;
    end
  end

  assign state_o     = state_q;
  assign cntr_en_o   = en_q;
  assign cntr_clr_o  = clr_q;
  assign cntr_load_o = load_q;
  assign th_lo_o     = th_lo_q;
  assign th_hi_o     = th_hi_q;
  assign pend_o      = pend_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_adv_timer_b_ctrl.sv
// Testbench for adv_timer_b_ctrl with N_REQ=2, CNT_W=16.
module tb_adv_timer_b_ctrl;
  localparam int N_REQ = 2;
  localparam int CNT_W = 16;

  localparam logic [2:0] NOP = 3'd0, START = 3'd1, STOP = 3'd2, UPD = 3'd3,
                         RST = 3'd4, ARM = 3'd5;

  typedef struct {
    logic        rstn;
    logic [1:0]  v;
    logic [2:0]  c0, c1;
    logic [15:0] l0, h0, l1, h1;
    logic        tg, ep;
    logic [1:0]  er, es;
    logic        een, eclr, eld, epd, eerr;
    logic [15:0] elo, ehi;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rstn;
  logic [N_REQ-1:0]       valid;
  logic [3*N_REQ-1:0]     cmd;
  logic [CNT_W*N_REQ-1:0] lo, hi;
  logic [N_REQ-1:0]       ready;
  logic                   trig, eop;
  logic                   en, clr, load, pend, err;
  logic [CNT_W-1:0]       th_lo, th_hi;
  logic [1:0]             state;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  adv_timer_b_ctrl #(.N_REQ(N_REQ), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rstn_i(rstn), .req_valid_i(valid), .req_cmd_i(cmd),
    .req_lo_i(lo), .req_hi_i(hi), .req_ready_o(ready), .trig_i(trig),
    .cntr_eop_i(eop), .cntr_en_o(en), .cntr_clr_o(clr), .cntr_load_o(load),
    .th_lo_o(th_lo), .th_hi_o(th_hi), .state_o(state), .pend_o(pend),
    .err_o(err)
  );

  function automatic vec_t mk(
    input logic rstn_v, input logic [1:0] v,
    input logic [2:0] c0, input logic [15:0] l0, h0,
    input logic [2:0] c1, input logic [15:0] l1, h1,
    input logic tg, ep, input logic [1:0] er, es,
    input logic een, eclr, eld, epd, eerr, input logic [15:0] elo, ehi);
    vec_t r;
    r.rstn = rstn_v; r.v = v; r.c0 = c0; r.l0 = l0; r.h0 = h0;
    r.c1 = c1; r.l1 = l1; r.h1 = h1; r.tg = tg; r.ep = ep;
    r.er = er; r.es = es; r.een = een; r.eclr = eclr; r.eld = eld;
    r.epd = epd; r.eerr = eerr; r.elo = elo; r.ehi = ehi;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    rstn  = v.rstn;
    valid = v.v;
    cmd   = {v.c1, v.c0};
    lo    = {v.l1, v.l0};
    hi    = {v.h1, v.h0};
    trig  = v.tg;
    eop   = v.ep;
    #1;
    chk("ready", idx, 32'(ready), 32'(v.er));
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("state", idx, 32'(state), 32'(e.es));
    chk("en",    idx, 32'(en),    32'(e.een));
    chk("clr",   idx, 32'(clr),   32'(e.eclr));
    chk("load",  idx, 32'(load),  32'(e.eld));
    chk("pend",  idx, 32'(pend),  32'(e.epd));
    chk("err",   idx, 32'(err),   32'(e.eerr));
    chk("th_lo", idx, 32'(th_lo), 32'(e.elo));
    chk("th_hi", idx, 32'(th_hi), 32'(e.ehi));
  endtask

  initial begin
    int n;
    rstn = 1'b0; valid = '0; cmd = '0; lo = '0; hi = '0; trig = 1'b0; eop = 1'b0;

    // reset with all valids high: no grant, everything zero
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,2'b11,START,0,0,START,0,0,0,0, 2'b00,0,0,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,0,0,0,0,0,0,16'h0,16'h0));
    // round robin: alternate 0,1,0,1 then only requester 1
    vecs.push_back(mk(1,2'b11,START,0,0,NOP,0,0,0,0, 2'b01,2,1,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b11,START,0,0,NOP,0,0,0,0, 2'b10,2,1,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b11,START,0,0,NOP,0,0,0,0, 2'b01,2,1,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b11,START,0,0,NOP,0,0,0,0, 2'b10,2,1,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b10,START,0,0,NOP,0,0,0,0, 2'b10,2,1,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b10,START,0,0,NOP,0,0,0,0, 2'b10,2,1,0,0,0,0,16'h0,16'h0));
    // shadowed updates in RUN, overwrite, apply at eop
    vecs.push_back(mk(1,2'b01,UPD,16'h0010,16'h0100,NOP,16'hAAAA,16'hBBBB,0,0, 2'b01,2,1,0,0,1,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b01,UPD,16'h0020,16'h0200,NOP,16'hAAAA,16'hBBBB,0,0, 2'b01,2,1,0,0,1,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,1, 2'b00,2,1,0,1,0,0,16'h0020,16'h0200));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,1, 2'b00,2,1,0,0,0,0,16'h0020,16'h0200));
    // requester-1 payload to shadow, then UPDATE together with eop (new data wins)
    vecs.push_back(mk(1,2'b10,NOP,16'hDEAD,16'hBEEF,UPD,16'h1234,16'h5678,0,0, 2'b10,2,1,0,0,1,0,16'h0020,16'h0200));
    vecs.push_back(mk(1,2'b01,UPD,16'h0AAA,16'h0BBB,NOP,16'h1234,16'h5678,0,1, 2'b01,2,1,0,1,0,0,16'h0AAA,16'h0BBB));
    // STOP with eop and pend: one load of the shadow
    vecs.push_back(mk(1,2'b01,UPD,16'h0777,16'h0888,NOP,0,0,0,0, 2'b01,2,1,0,0,1,0,16'h0AAA,16'h0BBB));
    vecs.push_back(mk(1,2'b10,NOP,0,0,STOP,0,0,0,1, 2'b10,0,0,0,1,0,0,16'h0777,16'h0888));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,0,0,0,0,0,0,16'h0777,16'h0888));
    // immediate update in IDLE; eop ignored in IDLE
    vecs.push_back(mk(1,2'b01,UPD,16'h0005,16'h000A,NOP,0,0,0,0, 2'b01,0,0,0,1,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,1, 2'b00,0,0,0,0,0,0,16'h0005,16'h000A));
    // ARM at T, trig at T+3
    vecs.push_back(mk(1,2'b10,NOP,0,0,ARM,0,0,0,0, 2'b10,1,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,1,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,1,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,1,0, 2'b00,2,1,0,0,0,0,16'h0005,16'h000A));
    // STOP + trig in ARMED -> IDLE; UPDATE + trig stays ARMED; NOP + trig -> RUN
    vecs.push_back(mk(1,2'b01,STOP,0,0,NOP,0,0,0,0, 2'b01,0,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b01,ARM,0,0,NOP,0,0,0,0, 2'b01,1,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b10,NOP,0,0,STOP,0,0,1,0, 2'b10,0,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b01,ARM,0,0,NOP,0,0,1,0, 2'b01,1,0,0,0,0,0,16'h0005,16'h000A));
    vecs.push_back(mk(1,2'b01,UPD,16'h0042,16'h0084,NOP,0,0,1,0, 2'b01,1,0,0,1,0,0,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b01,NOP,0,0,NOP,0,0,1,0, 2'b01,2,1,0,0,0,0,16'h0042,16'h0084));
    // RESET with pend and eop: clear only; back-to-back RESET pulses twice
    vecs.push_back(mk(1,2'b10,NOP,0,0,UPD,16'h0099,16'h0199,0,0, 2'b10,2,1,0,0,1,0,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b01,RST,0,0,NOP,0,0,0,1, 2'b01,0,0,1,0,0,0,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b01,RST,0,0,NOP,0,0,0,0, 2'b01,0,0,1,0,0,0,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,0,0,0,0,0,0,16'h0042,16'h0084));
    // illegal commands: err pulse, no state effect, ptr advances
    vecs.push_back(mk(1,2'b11,START,0,0,3'd7,0,0,0,0, 2'b10,0,0,0,0,0,1,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b11,START,0,0,3'd7,0,0,0,0, 2'b01,2,1,0,0,0,0,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b11,START,0,0,3'd6,0,0,0,0, 2'b10,2,1,0,0,0,1,16'h0042,16'h0084));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,2,1,0,0,0,0,16'h0042,16'h0084));
    // reset mid-operation with pend and eop: no load, all zero, ptr back to 0
    vecs.push_back(mk(1,2'b01,UPD,16'h3333,16'h4444,NOP,0,0,0,0, 2'b01,2,1,0,0,1,0,16'h0042,16'h0084));
    vecs.push_back(mk(0,2'b01,UPD,16'h3333,16'h4444,NOP,0,0,0,1, 2'b00,0,0,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b00,NOP,0,0,NOP,0,0,0,0, 2'b00,0,0,0,0,0,0,16'h0,16'h0));
    vecs.push_back(mk(1,2'b11,NOP,0,0,NOP,0,0,0,0, 2'b01,0,0,0,0,0,0,16'h0,16'h0));

    foreach (vecs[i]) apply(i, vecs[i]);

    // ARMED holds for a random number of idle cycles until the trigger
    apply(100, mk(1,2'b10,NOP,0,0,ARM,0,0,0,0, 2'b10,1,0,0,0,0,0,16'h0,16'h0));
    n = $urandom_range(1, 5);
    for (int k = 0; k < n; k++)
      apply(101 + k, mk(1,2'b00,NOP,0,0,NOP,0,0,0,1, 2'b00,1,0,0,0,0,0,16'h0,16'h0));
    apply(110, mk(1,2'b00,NOP,0,0,NOP,0,0,1,0, 2'b00,2,1,0,0,0,0,16'h0,16'h0));
    apply(111, mk(1,2'b00,NOP,0,0,NOP,0,0,0,1, 2'b00,2,1,0,0,0,0,16'h0,16'h0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
